conv_window_feeder: RTL and testbench
=====================================

# conv_window_feeder

Front-end sequencer for the 3x3 convolution core. It loads the 9 kernel coefficients into the core, column by column, using the core's 3-lane load protocol. It then accepts a raster-order 8-bit signed pixel stream and buffers the two previous image lines. Once the window is complete, it drives one 3-pixel vertical column per accepted pixel with the convolution-enable strobe. It sits between the pixel source (DMA/UART unpacker) and the convolution core's i_data1/2/3, i_en_conv and i_load_knl inputs.

## Interface
- IMG_WIDTH, 64: pixels per line; 3..1024.
- IMG_HEIGHT, 64: lines per frame; 3..1024.
- NB_PIX, 8: pixel/coefficient width, signed.
- clk  in  1  system clock, 100 MHz
- i_nrst  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle pulse; starts kernel load followed by one frame; ignored unless in IDLE
- i_kernel  in  9*NB_PIX  coefficients k1..k9, k1 at LSBs, row-major (k1..k3 = top row); sampled on i_start
- i_pix  in  NB_PIX  input pixel, raster order
- i_valid  in  1  i_pix valid
- o_ready  out  1  block accepts i_pix this cycle; transfer occurs when i_valid & o_ready
- o_data1  out  NB_PIX  top lane: row y-2 pixel, or kernel top-row coefficient
- o_data2  out  NB_PIX  middle lane: row y-1, or kernel middle-row coefficient
- o_data3  out  NB_PIX  bottom lane: row y (current), or kernel bottom-row coefficient
- o_en_conv  out  1  lanes carry a valid image column
- o_load_knl  out  1  lanes carry kernel load data
- o_col  out  10  column index x of the column currently presented
- o_row  out  10  row index y (current row) of the column currently presented
- o_busy  out  1  high in every state except IDLE
- o_frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted

## Operation
- States: IDLE, LOAD, FILL, STREAM, DONE. All outputs are registered.
- IDLE: o_ready=0. On i_start, latch i_kernel, clear the load counter c, and go to LOAD.
- LOAD: 4 cycles with o_load_knl=1 and o_en_conv=0.
  - For c=0..2, drive o_data1=k(1+c), o_data2=k(4+c), o_data3=k(7+c).
  - For c=3, drive all lanes 0; this cycle wraps the core's load counter back to 0.
  - After c=3, clear x, y and go to FILL.
- FILL (y=0,1): o_ready=1. Each accepted pixel is written into the line buffers. o_en_conv stays 0.
  - Counter rules: x increments; at x=IMG_WIDTH-1, x wraps to 0 and y increments.
  - On entering y=2, go to STREAM.
- STREAM (y>=2): o_ready=1. On an accepted pixel p at column x, the next cycle presents:
  - o_data1 = lb_old[x]
  - o_data2 = lb_new[x]
  - o_data3 = p
  - o_en_conv=1, o_col=x, o_row=y
- Line buffer update, every accepted pixel in FILL and STREAM: lb_old[x] <= lb_new[x]; lb_new[x] <= p. This is a read-before-write at the same address in the same cycle. lb_old/lb_new are NB_PIX x IMG_WIDTH arrays and are not reset.
- Last pixel (x=IMG_WIDTH-1, y=IMG_HEIGHT-1) accepted: present its column, pulse o_frame_done on that same output cycle, and go to DONE.
- DONE: one cycle with o_ready=0, then return to IDLE.
- o_en_conv and o_load_knl are never high together.
- Lane contents when idle:
  - When o_en_conv=0 and o_load_knl=0, lanes hold 0.
  - In cycles with no accepted pixel (i_valid=0 in STREAM), o_en_conv=0 and lanes hold 0. Column gaps are therefore visible to the core.
- i_start outside IDLE is ignored. i_valid outside FILL/STREAM is ignored; no pixel is consumed.

## Timing
- Reset (async assert, sync release) gives: state IDLE, o_ready=0, o_data1..3=0, o_en_conv=0, o_load_knl=0, o_col=0, o_row=0, o_busy=0, o_frame_done=0, c/x/y=0.
- Reset mid-frame aborts immediately. Buffered lines are discarded logically; the next frame starts with FILL again.
- i_start at cycle t gives o_load_knl high during t+1..t+4 and o_ready high from t+5.
- Pixel-to-column latency is 1 cycle. Throughput is 1 column per clock at full i_valid.
- Frame length at full rate: 1 + 4 + IMG_WIDTH*IMG_HEIGHT + 1 cycles from i_start back to IDLE.

## Test plan
- Kernel load: i_start with k1..k9 = 1..9 -> 4 o_load_knl cycles carrying lanes (1,4,7), (2,5,8), (3,6,9), (0,0,0); o_en_conv=0 throughout.
- Full-rate 4x4 frame, pixel = 4y+x -> no o_en_conv during rows 0-1. Row 2, x=1 presents (1,5,9). Row 3, x=3 presents (7,11,15). 8 columns total; o_frame_done coincides with column (3,3).
- Gapped i_valid (1 of every 3 cycles) on the same frame -> identical column sequence, o_en_conv low in gap cycles, lanes 0 in gaps.
- i_start pulsed during STREAM plus i_valid held high in IDLE/LOAD/DONE -> no restart, no extra pixels consumed, column count unchanged.
- Reset asserted at row 2, x=2 -> all outputs 0 immediately. A fresh i_start and frame produces the exact reference columns with no stale line data.
- Back-to-back frames at IMG_WIDTH=3, IMG_HEIGHT=3, with i_start on the cycle after DONE -> each frame yields exactly 3 columns, and the second frame's data is uncontaminated.

Source files
------------

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: front-end sequencer for the 3x3 convolution core.
// Loads the nine kernel coefficients column by column over the three lanes.
// It then buffers two image lines and presents one vertical 3-pixel column
// for every pixel accepted once two full lines are held.
module conv_window_feeder #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int NB_PIX     = 8
) (
  input  logic                  clk,
  input  logic                  i_nrst,
  input  logic                  i_start,
  input  logic [9*NB_PIX-1:0]   i_kernel,
  input  logic [NB_PIX-1:0]     i_pix,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [NB_PIX-1:0]     o_data1,
  output logic [NB_PIX-1:0]     o_data2,
  output logic [NB_PIX-1:0]     o_data3,
  output logic                  o_en_conv,
  output logic                  o_load_knl,
  output logic [9:0]            o_col,
  output logic [9:0]            o_row,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int         AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [9:0] X_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [9:0] Y_LAST = 10'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FILL   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Coefficient k(idx+1) of a packed kernel word (k1 at the LSBs).
  function automatic logic [NB_PIX-1:0] kernel_coef(input logic [9*NB_PIX-1:0] kernel,
                                                    input logic [3:0]          idx);
    return kernel[int'(idx)*NB_PIX +: NB_PIX];
  endfunction

  state_t                state_q;
  logic [9*NB_PIX-1:0]   kernel_q;
  logic [1:0]            c_q;
  logic [9:0]            x_q;
  logic [9:0]            y_q;

  // Line buffers carry only pixel data; FILL rewrites them before any read.
  logic [NB_PIX-1:0]     lb_old [IMG_WIDTH];
  logic [NB_PIX-1:0]     lb_new [IMG_WIDTH];

  logic                  accept_s;
  logic                  x_last_s;
  logic                  y_last_s;
  logic [AW-1:0]         x_addr_s;
  logic [NB_PIX-1:0]     lb_old_rd_s;
  logic [NB_PIX-1:0]     lb_new_rd_s;
  logic [3:0]            knl_idx_s;

  // Transfer strobe, counter end flags, buffer read port and next kernel column.
  always_comb begin
    accept_s    = i_valid & o_ready;
    x_last_s    = (x_q == X_LAST);
    y_last_s    = (y_q == Y_LAST);
    x_addr_s    = x_q[AW-1:0];
    lb_old_rd_s = lb_old[x_addr_s];
    lb_new_rd_s = lb_new[x_addr_s];
    knl_idx_s   = {2'b00, c_q} + 4'd1;
  end

  // Line buffer shift: the older line takes the newer one, the newer takes the pixel.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb_old[x_addr_s] <= lb_new[x_addr_s];
      lb_new[x_addr_s] <= i_pix;
    end
  end

  // Sequencer: kernel load, line fill, column streaming, all outputs registered.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= S_IDLE;
      kernel_q     <= '0;
      c_q          <= 2'd0;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      o_ready      <= 1'b0;
      o_data1      <= '0;
      o_data2      <= '0;
      o_data3      <= '0;
      o_en_conv    <= 1'b0;
      o_load_knl   <= 1'b0;
      o_col        <= 10'd0;
      o_row        <= 10'd0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      // Lanes are zero and strobes low unless a state below drives them.
      o_data1      <= '0;
      o_data2      <= '0;
      o_data3      <= '0;
      o_en_conv    <= 1'b0;
      o_load_knl   <= 1'b0;
      o_frame_done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            kernel_q   <= i_kernel;
            c_q        <= 2'd0;
            state_q    <= S_LOAD;
            o_busy     <= 1'b1;
            o_load_knl <= 1'b1;
            o_data1    <= kernel_coef(i_kernel, 4'd0);
            o_data2    <= kernel_coef(i_kernel, 4'd3);
            o_data3    <= kernel_coef(i_kernel, 4'd6);
          end
        end
        S_LOAD: begin
          // c_q is the column now on the lanes; drive the following one.
          c_q <= c_q + 2'd1;
          case (c_q)
            2'd0, 2'd1: begin
              o_load_knl <= 1'b1;
              o_data1    <= kernel_coef(kernel_q, knl_idx_s);
              o_data2    <= kernel_coef(kernel_q, knl_idx_s + 4'd3);
              o_data3    <= kernel_coef(kernel_q, knl_idx_s + 4'd6);
            end
            2'd2: begin
              // All-zero column wraps the core's load counter.
              o_load_knl <= 1'b1;
            end
            default: begin
              x_q     <= 10'd0;
              y_q     <= 10'd0;
              o_ready <= 1'b1;
              state_q <= S_FILL;
            end
          endcase
        end
        S_FILL: begin
          if (accept_s) begin
            if (x_last_s) begin
              x_q <= 10'd0;
              y_q <= y_q + 10'd1;
              if (y_q == 10'd1) begin
                state_q <= S_STREAM;
              end
            end else begin
              x_q <= x_q + 10'd1;
            end
          end
        end
        S_STREAM: begin
          if (accept_s) begin
            o_en_conv <= 1'b1;
            o_data1   <= lb_old_rd_s;
            o_data2   <= lb_new_rd_s;
            o_data3   <= i_pix;
            o_col     <= x_q;
            o_row     <= y_q;
            if (x_last_s) begin
              x_q <= 10'd0;
              if (y_last_s) begin
                o_ready      <= 1'b0;
                o_frame_done <= 1'b1;
                state_q      <= S_DONE;
              end else begin
                y_q <= y_q + 10'd1;
              end
            end else begin
              x_q <= x_q + 10'd1;
            end
          end
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          o_ready <= 1'b0;
          o_busy  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder: a 4x4 instance for kernel load,
// full-rate, gapped, ignored-control and abort scenarios, and a 3x3 instance
// for back-to-back frames.
module tb_conv_window_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst4, start4, valid4, ready4, en4, load4, busy4, fd4;
  logic [71:0] kern4;
  logic [7:0]  pix4, d1_4, d2_4, d3_4;
  logic [9:0]  col4, row4;

  logic        nrst3, start3, valid3, ready3, en3, load3, busy3, fd3;
  logic [71:0] kern3;
  logic [7:0]  pix3, d1_3, d2_3, d3_3;
  logic [9:0]  col3, row3;

  conv_window_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .NB_PIX(8)) dut4 (
    .clk(clk), .i_nrst(nrst4), .i_start(start4), .i_kernel(kern4), .i_pix(pix4),
    .i_valid(valid4), .o_ready(ready4), .o_data1(d1_4), .o_data2(d2_4), .o_data3(d3_4),
    .o_en_conv(en4), .o_load_knl(load4), .o_col(col4), .o_row(row4), .o_busy(busy4),
    .o_frame_done(fd4));

  conv_window_feeder #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .NB_PIX(8)) dut3 (
    .clk(clk), .i_nrst(nrst3), .i_start(start3), .i_kernel(kern3), .i_pix(pix3),
    .i_valid(valid3), .o_ready(ready3), .o_data1(d1_3), .o_data2(d2_3), .o_data3(d3_3),
    .o_en_conv(en3), .o_load_knl(load3), .o_col(col3), .o_row(row3), .o_busy(busy3),
    .o_frame_done(fd3));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Column record: {frame_done, row, col, lane1, lane2, lane3}
  logic [44:0] q4[$];
  logic [44:0] q3[$];
  int viol4 = 0;
  int viol3 = 0;

  // Capture every presented column; flag overlap of strobes and non-zero idle lanes.
  always @(negedge clk) begin
    if (nrst4) begin
      if (en4) q4.push_back({fd4, row4, col4, d1_4, d2_4, d3_4});
      if (en4 && load4) viol4++;
      if (!en4 && !load4 && ({d1_4, d2_4, d3_4} != 24'd0 || fd4)) viol4++;
    end
    if (nrst3) begin
      if (en3) q3.push_back({fd3, row3, col3, d1_3, d2_3, d3_3});
      if (en3 && load3) viol3++;
      if (!en3 && !load3 && ({d1_3, d2_3, d3_3} != 24'd0 || fd3)) viol3++;
    end
  end

  // Reference column for pixel value base + w*y + x.
  function automatic logic [44:0] col_exp(input int w, input int base, input int x,
                                          input int y, input logic fd);
    logic [7:0] a, b, c;
    a = 8'(base + w * (y - 2) + x);
    b = 8'(base + w * (y - 1) + x);
    c = 8'(base + w * y + x);
    return {fd, 10'(y), 10'(x), a, b, c};
  endfunction

  task automatic kick4(input logic do_chk);
    logic [71:0] k;
    logic [23:0] e;
    for (int i = 0; i < 9; i++) k[i*8 +: 8] = 8'(i + 1);
    @(posedge clk); #1;
    kern4  = k;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      e = (c < 3) ? {8'(c + 1), 8'(c + 4), 8'(c + 7)} : 24'd0;
      if (do_chk)
        check_eq($sformatf("load_c%0d", c), 64'({load4, en4, ready4, d1_4, d2_4, d3_4}),
                 64'({1'b1, 1'b0, 1'b0, e}));
      @(posedge clk); #1;
    end
    if (do_chk) check_eq("ready_after_load", 64'({load4, ready4, busy4}), 64'(3'b011));
  endtask

  // Offers pixels base+idx; valid on every period-th cycle. Returns on frame end or
  // right after accepting pixel abort_at-1 when abort_at >= 0.
  task automatic feed4(input int base, input int period, input int start_at,
                       input int abort_at, input logic hold);
    int   idx;
    int   cyc;
    logic rdy;
    logic pulsed;
    idx = 0; cyc = 0; pulsed = 1'b0;
    while (idx < 16 && cyc < 400) begin
      rdy    = ready4;
      valid4 = ((cyc % period) == 0);
      pix4   = 8'(base + idx);
      if (idx == start_at && !pulsed) begin
        start4 = 1'b1;
        pulsed = 1'b1;
      end
      @(posedge clk);
      if (valid4 && rdy) idx++;
      #1;
      cyc++;
      start4 = 1'b0;
      if (abort_at >= 0 && idx == abort_at) break;
    end
    valid4 = hold;
    pix4   = hold ? 8'd99 : 8'd0;
    if (abort_at < 0) begin
      check_eq("feed_count", 64'(idx), 64'd16);
      check_eq("done_state", 64'({ready4, busy4, fd4}), 64'(3'b011));
      @(posedge clk); #1;
      check_eq("idle_state", 64'({ready4, busy4, fd4}), 64'(3'b000));
    end
  endtask

  task automatic check_frame4(input int base, input string tag);
    check_eq({tag, "_ncol"}, 64'(q4.size()), 64'd8);
    for (int i = 0; i < q4.size() && i < 8; i++)
      check_eq($sformatf("%s_col%0d", tag, i), 64'(q4[i]),
               64'(col_exp(4, base, i % 4, 2 + i / 4, (i == 7))));
    q4.delete();
  endtask

  task automatic frame3(input int base);
    int   idx;
    int   cyc;
    logic rdy;
    @(posedge clk); #1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    valid3 = 1'b1;
    idx = 0; cyc = 0;
    while (idx < 9 && cyc < 60) begin
      pix3 = 8'(base + idx);
      rdy  = ready3;
      @(posedge clk);
      if (rdy) idx++;
      #1;
      cyc++;
    end
    valid3 = 1'b0;
    check_eq("f3_count", 64'(idx), 64'd9);
    check_eq("f3_done", 64'({ready3, busy3, fd3}), 64'(3'b011));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nrst4 = 1'b0; start4 = 1'b0; valid4 = 1'b0; pix4 = 8'd0; kern4 = 72'd0;
    nrst3 = 1'b0; start3 = 1'b0; valid3 = 1'b0; pix3 = 8'd0; kern3 = 72'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", 64'({ready4, en4, load4, busy4, fd4, d1_4, d2_4, d3_4}), 64'd0);
    check_eq("reset_pos", 64'({col4, row4}), 64'd0);
    @(negedge clk);
    nrst4 = 1'b1;
    nrst3 = 1'b1;

    // Kernel load and full-rate frame
    kick4(1'b1);
    feed4(0, 1, -1, -1, 1'b0);
    check_frame4(0, "full");

    // Valid on one cycle in three
    kick4(1'b0);
    feed4(0, 3, -1, -1, 1'b0);
    check_frame4(0, "gap");

    // Valid held high outside FILL/STREAM, start pulsed while streaming
    valid4 = 1'b1; pix4 = 8'd99;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_hold", 64'({ready4, busy4}), 64'd0);
    kick4(1'b0);
    feed4(0, 1, 10, -1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("no_restart", 64'({busy4, load4, ready4}), 64'd0);
    check_frame4(0, "hold");
    valid4 = 1'b0;

    // Abort at row 2, x=2, then a fresh frame with different pixels
    kick4(1'b0);
    feed4(0, 1, -1, 11, 1'b0);
    check_eq("abort_pre", 64'({en4, col4, row4, d3_4}), 64'({1'b1, 10'd2, 10'd2, 8'd10}));
    nrst4 = 1'b0;
    #1;
    check_eq("abort_outs", 64'({ready4, en4, load4, busy4, fd4, d1_4, d2_4, d3_4}), 64'd0);
    check_eq("abort_pos", 64'({col4, row4}), 64'd0);
    q4.delete();
    @(negedge clk);
    nrst4 = 1'b1;
    kick4(1'b0);
    feed4(100, 1, -1, -1, 1'b0);
    check_frame4(100, "fresh");

    // Back-to-back 3x3 frames, second start right after DONE
    frame3(0);
    frame3(50);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("f3_idle", 64'({busy3, ready3}), 64'd0);
    check_eq("f3_ncol", 64'(q3.size()), 64'd6);
    for (int i = 0; i < q3.size() && i < 6; i++)
      check_eq($sformatf("f3_col%0d", i), 64'(q3[i]),
               64'(col_exp(3, (i < 3) ? 0 : 50, i % 3, 2, ((i % 3) == 2))));

    check_eq("lanes_idle4", 64'(viol4), 64'd0);
    check_eq("lanes_idle3", 64'(viol3), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
